// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared constants, types and helpers for the audio output path.
//            SLOT_BITS/FRAME_BITS describe the 2 x 32-bit I2S frame,
//            sample_t is the default signed sample word, and bck_inc() gives
//            the phase-accumulator increment that yields two ticks per BCK
//            period (one per edge).
// Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SLOT_BITS        = 32;
    localparam int FRAME_BITS       = 64;
    localparam int DEFAULT_AUDIO_DW = 16;

    typedef logic signed [DEFAULT_AUDIO_DW-1:0] sample_t;

    // Accumulator increment for a BCK of FRAME_BITS x sample_rate: every
    // accumulator overflow is one BCK edge, so two overflows per bit.
    function automatic int unsigned bck_inc(input int unsigned sample_rate);
        return 2 * FRAME_BITS * sample_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frac_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : frac_clk_div
// Purpose  : Fractional clock-enable generator. A 32-bit phase accumulator
//            advances by OUT_RATE_X2 every clk and wraps modulo CLK_RATE;
//            each wrap produces a single-cycle tick, so the long-run tick
//            rate is exactly OUT_RATE_X2 per second of clk.
// Ports    : clk    - system clock
//            rst    - synchronous active-high reset (accumulator -> 0)
//            o_tick - combinational one-clk enable, at most one per clk
// Revision : 1.0 - initial release
// ============================================================================
module frac_clk_div #(
    parameter int unsigned CLK_RATE    = 14_000_000,
    parameter int unsigned OUT_RATE_X2 = 6_144_000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    // One extra bit so acc + INC can never overflow before the compare.
    localparam logic [32:0] c_clk_rate = 33'(CLK_RATE);
    localparam logic [32:0] c_inc      = 33'(OUT_RATE_X2);

    if (OUT_RATE_X2 == 0 || OUT_RATE_X2 > CLK_RATE) begin : g_rate_check
        $error("frac_clk_div: OUT_RATE_X2 must be in 1..CLK_RATE");
    end

    logic [31:0] r_acc_q;
    logic [31:0] w_acc_d;
    logic [32:0] w_sum;
    logic        w_tick;

    always_comb begin
        w_sum  = {1'b0, r_acc_q} + c_inc;
        w_tick = (w_sum >= c_clk_rate);
        // acc < CLK_RATE and INC <= CLK_RATE, so the wrapped value fits 32 bits.
        w_acc_d = w_tick ? 32'(w_sum - c_clk_rate) : w_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_q <= '0;
        end else begin
            r_acc_q <= w_acc_d;
        end
    end

    assign o_tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/i2s_frac_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_frac_tx
// Purpose  : Philips I2S transmitter running directly from the system clock.
//            BCK is toggled on ticks from a fractional divider; all data-side
//            outputs move only on BCK falling edges. Each frame is 64 BCK:
//            left slot then right slot, 32 bits each, data delayed one BCK
//            after the LRCK edge, MSB first, zero padded after the LSB.
// Ports    : clk           - system clock
//            reset         - synchronous active-high reset
//            left_chan     - left sample (two's complement), latched per frame
//            right_chan    - right sample (two's complement), latched per frame
//            sclk          - I2S bit clock (64 x SAMPLE_RATE on average)
//            lrclk         - word select, 0 = left slot, 1 = right slot
//            sdata         - serial data, MSB first
//            sample_strobe - one-clk pulse when a new L/R pair is latched
// Revision : 1.0 - initial release
// ============================================================================
module i2s_frac_tx
    import audio_pkg::*;
#(
    parameter int unsigned CLK_RATE    = 14_000_000,
    parameter int unsigned SAMPLE_RATE = 48_000,
    parameter int          AUDIO_DW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AUDIO_DW-1:0] left_chan,
    input  logic [AUDIO_DW-1:0] right_chan,
    output logic                sclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                sample_strobe
);

    localparam int               c_cnt_w   = $clog2(FRAME_BITS);
    localparam int               c_k_w     = $clog2(SLOT_BITS);
    localparam int unsigned      c_bck_inc = bck_inc(SAMPLE_RATE);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = 1;
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

    // At least 4 clk per BCK period keeps each BCK half-period >= 2 clk, so
    // sdata/lrclk are always stable for 2 clk before the codec samples them.
    if (CLK_RATE < 4 * FRAME_BITS * SAMPLE_RATE) begin : g_rate_check
        $error("i2s_frac_tx: CLK_RATE must be >= 256 x SAMPLE_RATE");
    end

    if (AUDIO_DW < 1 || AUDIO_DW > SLOT_BITS - 1) begin : g_dw_check
        $error("i2s_frac_tx: AUDIO_DW must be in 1..31");
    end

    // ------------------------------------------------------------------
    // BCK edge timing
    // ------------------------------------------------------------------
    logic w_tick;

    frac_clk_div #(
        .CLK_RATE    (CLK_RATE),
        .OUT_RATE_X2 (c_bck_inc)
    ) u_bck_div (
        .clk    (clk),
        .rst    (reset),
        .o_tick (w_tick)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                r_sclk_q,    w_sclk_d;
    logic                r_lrclk_q,   w_lrclk_d;
    logic                r_sdata_q,   w_sdata_d;
    logic                r_strobe_q,  w_strobe_d;
    logic [c_cnt_w-1:0]  r_bit_cnt_q, w_bit_cnt_d;
    logic [AUDIO_DW-1:0] r_left_q,    w_left_d;
    logic [AUDIO_DW-1:0] r_right_q,   w_right_d;

    logic                w_fall;
    logic [c_cnt_w-1:0]  w_cnt_inc;
    logic [AUDIO_DW-1:0] w_word;
    logic                w_bit;

    always_comb begin
        // A tick while BCK is high drives it low: that is the data edge.
        w_fall    = w_tick & r_sclk_q;
        w_sclk_d  = r_sclk_q ^ w_tick;
        w_cnt_inc = r_bit_cnt_q + c_cnt_one;

        // Slot bit k (1..AUDIO_DW) carries word bit AUDIO_DW-k; slot bit 0 is
        // the one-BCK I2S delay and bits beyond the LSB are padding, both 0.
        // For k == 0 the stale shadow is selected but never used.
        w_word = w_cnt_inc[c_cnt_w-1] ? r_right_q : r_left_q;
        w_bit  = 1'b0;
        for (int i = 0; i < AUDIO_DW; i++) begin
            if (int'(w_cnt_inc[c_k_w-1:0]) == AUDIO_DW - i) begin
                w_bit = w_word[i];
            end
        end

        w_bit_cnt_d = r_bit_cnt_q;
        w_lrclk_d   = r_lrclk_q;
        w_sdata_d   = r_sdata_q;
        w_left_d    = r_left_q;
        w_right_d   = r_right_q;
        w_strobe_d  = 1'b0;

        if (w_fall) begin
            w_bit_cnt_d = w_cnt_inc;
            w_lrclk_d   = w_cnt_inc[c_cnt_w-1];
            w_sdata_d   = w_bit;
            // Both channels are captured on the same clk so the pair stays
            // coherent for the whole frame.
            if (w_cnt_inc == c_cnt_zero) begin
                w_left_d   = left_chan;
                w_right_d  = right_chan;
                w_strobe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_q    <= 1'b0;
            r_lrclk_q   <= 1'b0;
            r_sdata_q   <= 1'b0;
            r_strobe_q  <= 1'b0;
            // Parked on the last bit so the first falling edge opens a frame.
            r_bit_cnt_q <= '1;
            r_left_q    <= '0;
            r_right_q   <= '0;
        end else begin
            r_sclk_q    <= w_sclk_d;
            r_lrclk_q   <= w_lrclk_d;
            r_sdata_q   <= w_sdata_d;
            r_strobe_q  <= w_strobe_d;
            r_bit_cnt_q <= w_bit_cnt_d;
            r_left_q    <= w_left_d;
            r_right_q   <= w_right_d;
        end
    end

    assign sclk          = r_sclk_q;
    assign lrclk         = r_lrclk_q;
    assign sdata         = r_sdata_q;
    assign sample_strobe = r_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_frac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_frac_tx
// Purpose  : Self-checking bench for i2s_frac_tx. A reference model derives
//            BCK edge times from floor(m * INC / CLK_RATE) and pushes the
//            expected latched pair and strobe cycle into queues; a monitor
//            decodes sdata/lrclk at BCK rising edges and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_frac_tx;

    localparam longint CLK_RATE    = 14_000_000;
    localparam longint SAMPLE_RATE = 48_000;
    localparam longint INC         = 2 * 64 * SAMPLE_RATE;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] left_chan  = 16'hFFFF;
    logic [15:0] right_chan = 16'hFFFF;
    logic        sclk, lrclk, sdata, sample_strobe;

    int checks = 0;
    int errors = 0;

    i2s_frac_tx #(
        .CLK_RATE    (14_000_000),
        .SAMPLE_RATE (48_000),
        .AUDIO_DW    (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .left_chan     (left_chan),
        .right_chan    (right_chan),
        .sclk          (sclk),
        .lrclk         (lrclk),
        .sdata         (sdata),
        .sample_strobe (sample_strobe)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: after m clk edges out of reset, exactly
    // floor(m*INC/CLK_RATE) BCK edges have occurred. Odd edges rise, even
    // edges fall; fall number f (1-based) opens a frame when f % 64 == 1.
    // ------------------------------------------------------------------
    int          cyc = 0;
    longint      m   = 0;
    logic [31:0] exp_q[$];
    int          strobe_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m = 0;
            exp_q.delete();
            strobe_q.delete();
        end else begin
            longint tn, tp;
            m++;
            tn = (m * INC) / CLK_RATE;
            tp = ((m - 1) * INC) / CLK_RATE;
            if (tn != tp && (tn % 2) == 0 && ((tn / 2) % 64) == 1) begin
                exp_q.push_back({left_chan, right_chan});
                strobe_q.push_back(cyc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int          rises    = 0;
    int          lr_rises = 0;
    int          frames   = 0;
    int          r        = 0;
    int          run      = 0;
    bit          ph_valid = 1'b0;
    logic        p_sclk   = 1'b0;
    logic        p_lr     = 1'b0;
    logic        p_rst    = 1'b1;
    logic [31:0] lslot, rslot;
    logic [63:0] lrpat;

    initial forever begin
        @(negedge clk);

        if (sample_strobe) begin
            checks++;
            if (strobe_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: sample_strobe=1 at cycle %0d, required 0", cyc);
            end else begin
                int e;
                e = strobe_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL strobe_cycle: got cycle %0d, required %0d", cyc, e);
                end
            end
        end
        while (strobe_q.size() > 0 && strobe_q[0] < cyc) begin
            int e;
            e = strobe_q.pop_front();
            checks++;
            errors++;
            $display("FAIL strobe_missing: no strobe at cycle %0d, required 1", e);
        end

        if (p_rst) begin
            checks++;
            if ({sclk, lrclk, sdata, sample_strobe} != 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: got sclk/lrclk/sdata/strobe=%b, required 0000",
                         {sclk, lrclk, sdata, sample_strobe});
            end
        end

        if (reset) begin
            r        = 0;
            run      = 0;
            ph_valid = 1'b0;
            p_sclk   = 1'b0;
        end else begin
            if (sclk != p_sclk) begin
                if (ph_valid) begin
                    checks++;
                    if (run < 2 || run > 3) begin
                        errors++;
                        $display("FAIL bck_phase: got %0d clk, required 2 or 3 (cycle %0d)", run, cyc);
                    end
                end
                ph_valid = 1'b1;
                run      = 1;
                if (sclk) begin
                    rises++;
                    r++;
                    if (r == 1) begin
                        checks++;
                        if (sdata !== 1'b0 || lrclk !== 1'b0) begin
                            errors++;
                            $display("FAIL first_rise: got sdata=%b lrclk=%b, required 0 0", sdata, lrclk);
                        end
                    end else begin
                        int pos;
                        pos = (r - 2) % 64;
                        if (pos < 32) lslot = {lslot[30:0], sdata};
                        else          rslot = {rslot[30:0], sdata};
                        lrpat = {lrpat[62:0], lrclk};
                        if (pos == 63) begin
                            logic [31:0] e;
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL frame_unexpected: got frame L=%h R=%h, required none", lslot, rslot);
                            end else begin
                                e = exp_q.pop_front();
                                frames++;
                                if (lslot !== {1'b0, e[31:16], 15'd0}) begin
                                    errors++;
                                    $display("FAIL left_slot: got %h, required %h", lslot, {1'b0, e[31:16], 15'd0});
                                end
                                checks++;
                                if (rslot !== {1'b0, e[15:0], 15'd0}) begin
                                    errors++;
                                    $display("FAIL right_slot: got %h, required %h", rslot, {1'b0, e[15:0], 15'd0});
                                end
                                checks++;
                                if (lrpat !== {32'h0000_0000, 32'hFFFF_FFFF}) begin
                                    errors++;
                                    $display("FAIL lrclk_pattern: got %h, required %h", lrpat, {32'h0000_0000, 32'hFFFF_FFFF});
                                end
                            end
                        end
                    end
                end
            end else begin
                run++;
            end
            p_sclk = sclk;
        end

        if (lrclk && !p_lr) lr_rises++;
        p_lr  = lrclk;
        p_rst = reset;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_strobe();
        int n;
        n = 0;
        @(negedge clk);
        while (!sample_strobe && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!sample_strobe) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: got none in 1000 clk, required one per frame");
        end
        step(1);
    endtask

    initial begin
        int r0, lr0;

        // Reset held 5 clk with all-ones inputs.
        step(5);
        left_chan  = 16'hA5C3;
        right_chan = 16'h0001;
        reset      = 1'b0;

        // 1 ms window at the default rates.
        r0  = rises;
        lr0 = lr_rises;
        step(14000);
        checks++;
        if (rises - r0 < 3071 || rises - r0 > 3073) begin
            errors++;
            $display("FAIL sclk_rate: got %0d rising edges, required 3072 +/-1", rises - r0);
        end
        checks++;
        if (lr_rises - lr0 < 47 || lr_rises - lr0 > 49) begin
            errors++;
            $display("FAIL lrclk_rate: got %0d rising edges, required 48 +/-1", lr_rises - lr0);
        end

        // Full-scale extremes.
        left_chan  = 16'h8000;
        right_chan = 16'h7FFF;
        step(900);

        // Input change mid-frame must only show up in the following frame.
        left_chan = 16'h1111;
        wait_strobe();
        wait_strobe();
        step(46);
        left_chan = 16'h2222;
        step(700);

        // Random samples changing at random times.
        repeat (20) begin
            left_chan  = 16'($urandom);
            right_chan = 16'($urandom);
            step($urandom_range(50, 400));
        end

        // One-clk reset about 20 bits into a frame.
        wait_strobe();
        step(90);
        reset = 1'b1;
        step(1);
        reset = 1'b0;

        repeat (6) begin
            left_chan  = 16'($urandom);
            right_chan = 16'($urandom);
            step($urandom_range(100, 300));
        end
        step(700);

        checks++;
        if (frames < 50) begin
            errors++;
            $display("FAIL frame_count: got %0d frames, required at least 50", frames);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
